// File: rtl/iserdes_align_pkg.sv
// iserdes_align_pkg
// Shared types and constants for the I_SERDES word aligner.
//   align_state_t : per-channel training FSM state
//   WIDTH_MIN/MAX : legal deserialisation ratio range
//   NUM_CH_MIN/MAX: legal channel count range
package iserdes_align_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HUNT   = 3'd1,
      SLIP   = 3'd2,
      SETTLE = 3'd3,
      LOCKED = 3'd4,
      ERROR  = 3'd5
   } align_state_t;

   localparam int unsigned WIDTH_MIN  = 3;
   localparam int unsigned WIDTH_MAX  = 10;
   localparam int unsigned NUM_CH_MIN = 1;
   localparam int unsigned NUM_CH_MAX = 16;

endpackage

// File: rtl/iserdes_align_ch.sv
// iserdes_align_ch
// One channel of the word aligner: training FSM, saturating counters and the
// registered output word.
//   clk, rst_n      : fabric clock, async active-low reset
//   pll_lock        : PLL lock; low forces IDLE
//   train           : training request level (starts training from IDLE)
//   train_rise      : one-cycle rising edge of train (retrain from LOCKED/ERROR)
//   din, din_valid  : deserialised word from the I_SERDES
//   bitslip         : single-cycle pulse to BITSLIP_ADJ
//   dout, dout_valid: registered word, valid only while aligned
//   aligned         : channel locked
//   align_err       : every phase tried without a match
module iserdes_align_ch
   import iserdes_align_pkg::*;
#(
   parameter int unsigned      WIDTH         = 4,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'b1100,
   parameter int unsigned      MATCH_COUNT   = 8,
   parameter int unsigned      SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_lock,
   input  logic             train,
   input  logic             train_rise,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             bitslip,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             aligned,
   output logic             align_err
);

   localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
   localparam int unsigned SW = $clog2(WIDTH + 1);
   localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [MW-1:0] MatchMax  = MW'(MATCH_COUNT);
   localparam logic [SW-1:0] SlipMax   = SW'(WIDTH);
   localparam logic [TW-1:0] SettleMax = TW'(SETTLE_CYCLES);

   align_state_t    state_q, state_d;
   logic [MW-1:0]   match_cnt_q, match_cnt_d;
   logic [SW-1:0]   slip_cnt_q, slip_cnt_d;
   logic [TW-1:0]   settle_cnt_q, settle_cnt_d;
   logic [WIDTH-1:0] dout_q;
   logic            dout_valid_q;

   always_comb begin
      state_d      = state_q;
      match_cnt_d  = match_cnt_q;
      slip_cnt_d   = slip_cnt_q;
      settle_cnt_d = settle_cnt_q;

      if (!pll_lock) begin
         // Loss of lock beats any simultaneous match or train edge.
         state_d      = IDLE;
         match_cnt_d  = '0;
         slip_cnt_d   = '0;
         settle_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               match_cnt_d  = '0;
               slip_cnt_d   = '0;
               settle_cnt_d = '0;
               if (train) state_d = HUNT;
            end
            HUNT: begin
               if (din_valid) begin
                  if (din == TRAIN_PATTERN) begin
                     if (match_cnt_q != MatchMax) match_cnt_d = match_cnt_q + 1'b1;
                     if (match_cnt_d == MatchMax) state_d = LOCKED;
                  end else begin
                     match_cnt_d = '0;
                     // Initial phase plus WIDTH slips have all failed.
                     state_d = (slip_cnt_q == SlipMax) ? ERROR : SLIP;
                  end
               end
            end
            SLIP: begin
               if (slip_cnt_q != SlipMax) slip_cnt_d = slip_cnt_q + 1'b1;
               settle_cnt_d = '0;
               state_d      = SETTLE;
            end
            SETTLE: begin
               if (settle_cnt_q != SettleMax) settle_cnt_d = settle_cnt_q + 1'b1;
               if (settle_cnt_d == SettleMax) state_d = HUNT;
            end
            LOCKED: begin
               if (train_rise) begin
                  state_d     = HUNT;
                  match_cnt_d = '0;
                  slip_cnt_d  = '0;
               end
            end
            ERROR: begin
               if (train_rise) begin
                  state_d      = HUNT;
                  match_cnt_d  = '0;
                  slip_cnt_d   = '0;
                  settle_cnt_d = '0;
               end
            end
            default: begin
               state_d      = IDLE;
               match_cnt_d  = '0;
               slip_cnt_d   = '0;
               settle_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         match_cnt_q  <= '0;
         slip_cnt_q   <= '0;
         settle_cnt_q <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         match_cnt_q  <= match_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         if (din_valid) dout_q <= din;
         // Keyed off the next state so valid tracks ALIGNED on the same edge.
         dout_valid_q <= din_valid && (state_d == LOCKED);
      end
   end

   assign bitslip    = (state_q == SLIP);
   assign aligned    = (state_q == LOCKED);
   assign align_err  = (state_q == ERROR);
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule

// File: rtl/iserdes_word_aligner.sv
// iserdes_word_aligner
// Multi-channel word aligner for I_SERDES outputs. Each channel trains
// independently by bitslipping until TRAIN_PATTERN is seen MATCH_COUNT times.
// WIDTH legal 3..10, NUM_CH legal 1..16.
//   CLK, RST_N  : fabric clock (I_SERDES CLK_OUT domain), async active-low reset
//   PLL_LOCK    : PLL lock indication
//   TRAIN       : training request level; rising edge retrains locked/failed channels
//   DIN         : concatenated Q words, channel c at [c*WIDTH +: WIDTH]
//   DIN_VALID   : per-channel DATA_VALID
//   BITSLIP     : per-channel BITSLIP_ADJ pulse
//   DOUT        : registered words
//   DOUT_VALID  : per-channel word valid (aligned channels only)
//   ALIGNED     : per-channel lock
//   ALIGN_ERR   : per-channel training failure
//   ALL_ALIGNED : registered AND of ALIGNED
module iserdes_word_aligner
   import iserdes_align_pkg::*;
#(
   parameter int unsigned      WIDTH         = 4,
   parameter int unsigned      NUM_CH        = 1,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'b1100,
   parameter int unsigned      MATCH_COUNT   = 8,
   parameter int unsigned      SETTLE_CYCLES = 4
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    PLL_LOCK,
   input  logic                    TRAIN,
   input  logic [NUM_CH*WIDTH-1:0] DIN,
   input  logic [NUM_CH-1:0]       DIN_VALID,
   output logic [NUM_CH-1:0]       BITSLIP,
   output logic [NUM_CH*WIDTH-1:0] DOUT,
   output logic [NUM_CH-1:0]       DOUT_VALID,
   output logic [NUM_CH-1:0]       ALIGNED,
   output logic [NUM_CH-1:0]       ALIGN_ERR,
   output logic                    ALL_ALIGNED
);

   logic train_q;
   logic train_rise;
   logic all_aligned_q;

   // One edge detector shared by every channel.
   assign train_rise = TRAIN && !train_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         train_q       <= 1'b0;
         all_aligned_q <= 1'b0;
      end else begin
         train_q       <= TRAIN;
         all_aligned_q <= &ALIGNED;
      end
   end

   assign ALL_ALIGNED = all_aligned_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      iserdes_align_ch #(
         .WIDTH         (WIDTH),
         .TRAIN_PATTERN (TRAIN_PATTERN),
         .MATCH_COUNT   (MATCH_COUNT),
         .SETTLE_CYCLES (SETTLE_CYCLES)
      ) u_ch (
         .clk        (CLK),
         .rst_n      (RST_N),
         .pll_lock   (PLL_LOCK),
         .train      (TRAIN),
         .train_rise (train_rise),
         .din        (DIN[c*WIDTH +: WIDTH]),
         .din_valid  (DIN_VALID[c]),
         .bitslip    (BITSLIP[c]),
         .dout       (DOUT[c*WIDTH +: WIDTH]),
         .dout_valid (DOUT_VALID[c]),
         .aligned    (ALIGNED[c]),
         .align_err  (ALIGN_ERR[c])
      );
   end

endmodule

// File: tb/tb_iserdes_word_aligner.sv
// tb_iserdes_word_aligner
// Two-channel bench. The I_SERDES model rotates each channel's source word by
// one bit per observed BITSLIP pulse. Expected outputs per step come from an
// event planner that scans the valid pattern for the first sample of each
// phase, deriving pulse, lock and error steps.
module tb_iserdes_word_aligner;

   localparam int W    = 4;
   localparam int NCH  = 2;
   localparam int MC   = 8;
   localparam int S    = 4;
   localparam int MAXT = 300;
   localparam logic [W-1:0] PAT = 4'b1100;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             PLL_LOCK = 1'b0;
   logic             TRAIN = 1'b0;
   logic [NCH*W-1:0] DIN = '0;
   logic [NCH-1:0]   DIN_VALID = '0;
   logic [NCH-1:0]   BITSLIP;
   logic [NCH*W-1:0] DOUT;
   logic [NCH-1:0]   DOUT_VALID;
   logic [NCH-1:0]   ALIGNED;
   logic [NCH-1:0]   ALIGN_ERR;
   logic             ALL_ALIGNED;

   int checks = 0;
   int errors = 0;

   int         need   [NCH];
   logic [W-1:0] src  [NCH];
   int         slips  [NCH];
   int         npulse [NCH];
   logic [W-1:0] exp_dout [NCH];
   bit v  [NCH][MAXT];
   bit pl [MAXT];
   bit tr [MAXT];
   bit exp_bs [NCH][MAXT];
   bit exp_al [NCH][MAXT];
   bit exp_er [NCH][MAXT];
   bit prev_both;

   always #5 CLK = ~CLK;

   iserdes_word_aligner #(
      .WIDTH         (W),
      .NUM_CH        (NCH),
      .TRAIN_PATTERN (PAT),
      .MATCH_COUNT   (MC),
      .SETTLE_CYCLES (S)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .PLL_LOCK    (PLL_LOCK),
      .TRAIN       (TRAIN),
      .DIN         (DIN),
      .DIN_VALID   (DIN_VALID),
      .BITSLIP     (BITSLIP),
      .DOUT        (DOUT),
      .DOUT_VALID  (DOUT_VALID),
      .ALIGNED     (ALIGNED),
      .ALIGN_ERR   (ALIGN_ERR),
      .ALL_ALIGNED (ALL_ALIGNED)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Source word after s slips; needs need[c] slips to show the pattern.
   function automatic logic [W-1:0] word_at(input int c, input int s);
      int r;
      logic [W-1:0] w;
      r = (W - need[c] + s) % W;
      w = src[c];
      for (int i = 0; i < r; i++) w = {w[W-2:0], w[W-1]};
      return w;
   endfunction

   function automatic void idle_from(input int c, input int t0);
      for (int k = t0; k < MAXT; k++) begin
         exp_bs[c][k] = 1'b0;
         exp_al[c][k] = 1'b0;
         exp_er[c][k] = 1'b0;
      end
   endfunction

   // Channel c starts hunting with the sample of step h0.
   function automatic void plan(input int c, input int h0);
      int h, t, m, base;
      base = slips[c];
      idle_from(c, h0 - 1);
      h = h0;
      for (int p = 0; p <= W; p++) begin
         t = h;
         while (t < MAXT && !v[c][t]) t++;
         if (t >= MAXT) return;
         if (word_at(c, base + p) == PAT) begin
            m = 0;
            while (t < MAXT) begin
               if (v[c][t]) begin
                  m++;
                  if (m == MC) begin
                     for (int k = t; k < MAXT; k++) exp_al[c][k] = 1'b1;
                     return;
                  end
               end
               t++;
            end
            return;
         end
         if (p == W) begin
            for (int k = t; k < MAXT; k++) exp_er[c][k] = 1'b1;
            return;
         end
         exp_bs[c][t] = 1'b1;
         h = t + 2 + S;
      end
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, ".bitslip"}, 32'(BITSLIP), 32'd0);
      chk({tag, ".aligned"}, 32'(ALIGNED), 32'd0);
      chk({tag, ".align_err"}, 32'(ALIGN_ERR), 32'd0);
      chk({tag, ".dout_valid"}, 32'(DOUT_VALID), 32'd0);
      chk({tag, ".dout"}, 32'(DOUT), 32'd0);
      chk({tag, ".all_aligned"}, 32'(ALL_ALIGNED), 32'd0);
   endtask

   // Reset, then prepare a training run. vmode: 0 always, 1 even steps, 2 random.
   task automatic start(input int n0, input int n1, input logic [W-1:0] s0,
                        input logic [W-1:0] s1, input int vm0, input int vm1);
      int vm;
      RST_N = 1'b0;
      PLL_LOCK = 1'b0;
      TRAIN = 1'b0;
      DIN = '0;
      DIN_VALID = '0;
      @(negedge CLK);
      chk_zero("reset");
      RST_N = 1'b1;
      @(negedge CLK);
      need[0] = n0;
      need[1] = n1;
      src[0] = s0;
      src[1] = s1;
      prev_both = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         slips[c] = 0;
         npulse[c] = 0;
         exp_dout[c] = '0;
         vm = (c == 0) ? vm0 : vm1;
         for (int t = 0; t < MAXT; t++) begin
            if (vm == 0) v[c][t] = 1'b1;
            else if (vm == 1) v[c][t] = (t % 2 == 0);
            else v[c][t] = ($urandom_range(0, 3) != 0);
         end
      end
      for (int t = 0; t < MAXT; t++) begin
         pl[t] = 1'b1;
         tr[t] = 1'b1;
      end
      plan(0, 1);
      plan(1, 1);
   endtask

   task automatic run(input int from, input int to);
      for (int t = from; t < to; t++) begin
         PLL_LOCK = pl[t];
         TRAIN = tr[t];
         for (int c = 0; c < NCH; c++) begin
            DIN[c*W +: W] = word_at(c, slips[c]);
            DIN_VALID[c] = v[c][t];
            if (v[c][t]) exp_dout[c] = word_at(c, slips[c]);
         end
         @(posedge CLK);
         @(negedge CLK);
         for (int c = 0; c < NCH; c++) begin
            chk($sformatf("bitslip[%0d]@%0d", c, t), 32'(BITSLIP[c]), 32'(exp_bs[c][t]));
            chk($sformatf("aligned[%0d]@%0d", c, t), 32'(ALIGNED[c]), 32'(exp_al[c][t]));
            chk($sformatf("align_err[%0d]@%0d", c, t), 32'(ALIGN_ERR[c]), 32'(exp_er[c][t]));
            chk($sformatf("dout_valid[%0d]@%0d", c, t), 32'(DOUT_VALID[c]),
                32'(exp_al[c][t] && v[c][t]));
            chk($sformatf("dout[%0d]@%0d", c, t), 32'(DOUT[c*W +: W]), 32'(exp_dout[c]));
         end
         chk($sformatf("all_aligned@%0d", t), 32'(ALL_ALIGNED), 32'(prev_both));
         prev_both = exp_al[0][t] && exp_al[1][t];
         for (int c = 0; c < NCH; c++) begin
            if (BITSLIP[c]) begin
               slips[c]++;
               npulse[c]++;
            end
         end
      end
   endtask

   initial begin
      @(negedge CLK);

      // Aligned start on ch0, two slips needed on ch1, then a TRAIN re-edge.
      start(0, 2, PAT, PAT, 0, 0);
      tr[80] = 1'b0;
      run(0, 81);
      chk("a.pulses0", 32'(npulse[0]), 32'd0);
      chk("a.pulses1", 32'(npulse[1]), 32'd2);
      plan(0, 82);
      plan(1, 82);
      run(81, 140);

      // No pattern: every phase fails; ch1 sees valid every other cycle.
      start(0, 0, 4'b0000, 4'b0000, 0, 1);
      tr[120] = 1'b0;
      run(0, 121);
      chk("b.pulses0", 32'(npulse[0]), 32'(W));
      chk("b.pulses1", 32'(npulse[1]), 32'(W));
      plan(0, 122);
      plan(1, 122);
      run(121, 200);
      chk("b.retrain_pulses0", 32'(npulse[0]), 32'(2 * W));

      // Offsets 0 and 3 with valid gaps, then PLL loss and recovery.
      start(0, 3, PAT, PAT, 1, 1);
      pl[60] = 1'b0;
      run(0, 60);
      chk("c.pulses1", 32'(npulse[1]), 32'd3);
      idle_from(0, 60);
      idle_from(1, 60);
      plan(0, 62);
      plan(1, 62);
      run(60, 120);

      // Randomised offsets and valid density.
      for (int it = 0; it < 3; it++) begin
         start(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), PAT, PAT, 2, 2);
         run(0, 150);
         chk("d.pulses0", 32'(npulse[0]), 32'(need[0]));
         chk("d.pulses1", 32'(npulse[1]), 32'(need[1]));
      end

      // Asynchronous reset in the middle of SETTLE.
      start(0, 0, 4'b0000, PAT, 0, 0);
      run(0, 3);
      chk("e.pulse_seen", 32'(npulse[0]), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      chk_zero("async_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
